// File: rtl/uart_frame_parser_if.sv
// Byte-in / buffer-write-out bundle of the UART frame parser.
interface uart_frame_parser_if #(
   parameter int NUMBER    = 256,
   parameter int LEN_BYTES = 1
);
   localparam int AW = $clog2(NUMBER);
   localparam int LW = 8 * LEN_BYTES;

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic [7:0]    cmd_rx;
   logic [LW-1:0] len_rx;
   logic [7:0]    wr_data;
   logic [AW-1:0] wr_addr;
   logic          we;
   logic          rx_done;
   logic          rx_err;
   logic [1:0]    err_code;
   logic          busy;

   modport master (
      output rx_data, rx_valid,
      input  cmd_rx, len_rx, wr_data, wr_addr, we,
      input  rx_done, rx_err, err_code, busy
   );

   modport slave (
      input  rx_data, rx_valid,
      output cmd_rx, len_rx, wr_data, wr_addr, we,
      output rx_done, rx_err, err_code, busy
   );
endinterface

// File: rtl/uart_frame_parser.sv
// Frame parser: cmd, len, payload[len] (+ checksum when UART_FRAME_CHECKSUM_EN
// is defined); writes payload to the command buffer, flags done/error.
module uart_frame_parser #(
   parameter int CLOCK      = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int NUMBER     = 256,
   parameter int LEN_BYTES  = 1,
   parameter int RX_TIMEOUT = 2
) (
   input logic                clk,
   input logic                reset,
   uart_frame_parser_if.slave bus
);
   localparam int LW     = 8 * LEN_BYTES;
   localparam int AW     = $clog2(NUMBER);
   localparam int CW     = $clog2(NUMBER + 1);
   localparam int TO_LIM = RX_TIMEOUT * ((10 * CLOCK) / BAUD);
   localparam int TW     = $clog2(TO_LIM + 1);
   localparam logic [31:0] NUM32 = NUMBER;

`ifdef UART_FRAME_CHECKSUM_EN
   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DROP} state_t;
`else
   typedef enum logic [2:0] {IDLE, LEN, DATA, DROP} state_t;
`endif

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] len_q, len_d, len_nx;
   logic [TW-1:0] to_q, to_d;
   logic [7:0]    cmd_q, cmd_d;
   logic [LW-1:0] len_rx_q, len_rx_d;
   logic [7:0]    wr_data_q, wr_data_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic          we_q, we_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic [1:0]    code_q, code_d;
   logic          busy_q;
   logic          expire;
`ifdef UART_FRAME_CHECKSUM_EN
   logic [7:0]    sum_q, sum_d;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      to_d      = to_q;
      cmd_d     = cmd_q;
      len_rx_d  = len_rx_q;
      wr_data_d = wr_data_q;
      wr_addr_d = wr_addr_q;
      we_d      = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      code_d    = code_q;
`ifdef UART_FRAME_CHECKSUM_EN
      sum_d     = sum_q;
`endif
      // Length bytes arrive LSB first: shift each new byte in at the top.
      len_nx = LW'({bus.rx_data, len_q} >> 8);
      expire = (state_q != IDLE) && !bus.rx_valid
               && (to_q == TW'(TO_LIM - 1));
      if (state_q != IDLE)
         to_d = bus.rx_valid ? '0 : to_q + TW'(1);

      unique case (state_q)
         IDLE: begin
            if (bus.rx_valid) begin
               cmd_d   = bus.rx_data;
               cnt_d   = '0;
               len_d   = '0;
               to_d    = '0;
               state_d = LEN;
`ifdef UART_FRAME_CHECKSUM_EN
               sum_d   = bus.rx_data;
`endif
            end
         end
         LEN: begin
            if (bus.rx_valid) begin
               len_d = len_nx;
               cnt_d = cnt_q + CW'(1);
`ifdef UART_FRAME_CHECKSUM_EN
               sum_d = sum_q + bus.rx_data;
`endif
               if (cnt_q == CW'(LEN_BYTES - 1)) begin
                  cnt_d = '0;
                  if (32'(len_nx) > NUM32) begin
                     err_d   = 1'b1;
                     code_d  = 2'd3;
                     state_d = DROP;
                  end else if (len_nx == '0) begin
`ifdef UART_FRAME_CHECKSUM_EN
                     state_d  = CSUM;
`else
                     done_d   = 1'b1;
                     len_rx_d = len_nx;
                     code_d   = 2'd0;
                     state_d  = IDLE;
`endif
                  end else begin
                     state_d = DATA;
                  end
               end
            end
         end
         DATA: begin
            if (bus.rx_valid) begin
               wr_data_d = bus.rx_data;
               wr_addr_d = cnt_q[AW-1:0];
               we_d      = 1'b1;
               cnt_d     = cnt_q + CW'(1);
`ifdef UART_FRAME_CHECKSUM_EN
               sum_d     = sum_q + bus.rx_data;
`endif
               if (32'(cnt_q) + 32'd1 == 32'(len_q)) begin
                  cnt_d = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                  state_d  = CSUM;
`else
                  done_d   = 1'b1;
                  len_rx_d = len_q;
                  code_d   = 2'd0;
                  state_d  = IDLE;
`endif
               end
            end
         end
`ifdef UART_FRAME_CHECKSUM_EN
         CSUM: begin
            if (bus.rx_valid) begin
               state_d = IDLE;
               if (bus.rx_data == ~sum_q) begin
                  done_d   = 1'b1;
                  len_rx_d = len_q;
                  code_d   = 2'd0;
               end else begin
                  err_d  = 1'b1;
                  code_d = 2'd1;
               end
            end
         end
`endif
         DROP: ;
         default: state_d = IDLE;
      endcase

      // DROP already reported its overflow, so its expiry is silent.
      if (expire) begin
         state_d = IDLE;
         cnt_d   = '0;
         to_d    = '0;
         if (state_q != DROP) begin
            err_d  = 1'b1;
            code_d = 2'd2;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         len_q     <= '0;
         to_q      <= '0;
         cmd_q     <= '0;
         len_rx_q  <= '0;
         wr_data_q <= '0;
         wr_addr_q <= '0;
         we_q      <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= '0;
         busy_q    <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
         sum_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         len_q     <= len_d;
         to_q      <= to_d;
         cmd_q     <= cmd_d;
         len_rx_q  <= len_rx_d;
         wr_data_q <= wr_data_d;
         wr_addr_q <= wr_addr_d;
         we_q      <= we_d;
         done_q    <= done_d;
         err_q     <= err_d;
         code_q    <= code_d;
         busy_q    <= (state_d != IDLE);
`ifdef UART_FRAME_CHECKSUM_EN
         sum_q     <= sum_d;
`endif
      end
   end

   assign bus.cmd_rx   = cmd_q;
   assign bus.len_rx   = len_rx_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.we       = we_q;
   assign bus.rx_done  = done_q;
   assign bus.rx_err   = err_q;
   assign bus.err_code = code_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: three instances (default, NUMBER=4,
// LEN_BYTES=2) share one byte stream; each scenario checks one of them.
module tb_uart_frame_parser;
   localparam int CLK_HZ = 1_152_000;
   localparam int BD     = 115_200;
   localparam int RXT    = 2;
   localparam int TO_LIM = RXT * ((10 * CLK_HZ) / BD);
`ifdef UART_FRAME_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_d = 8'h00;
   logic       rx_v = 1'b0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_frame_parser_if #(.NUMBER(256), .LEN_BYTES(1)) if_a ();
   uart_frame_parser_if #(.NUMBER(4),   .LEN_BYTES(1)) if_b ();
   uart_frame_parser_if #(.NUMBER(256), .LEN_BYTES(2)) if_c ();

   assign if_a.rx_data = rx_d;
   assign if_a.rx_valid = rx_v;
   assign if_b.rx_data = rx_d;
   assign if_b.rx_valid = rx_v;
   assign if_c.rx_data = rx_d;
   assign if_c.rx_valid = rx_v;

   uart_frame_parser #(.CLOCK(CLK_HZ), .BAUD(BD), .NUMBER(256),
      .LEN_BYTES(1), .RX_TIMEOUT(RXT))
      u_a (.clk(clk), .reset(reset), .bus(if_a));
   uart_frame_parser #(.CLOCK(CLK_HZ), .BAUD(BD), .NUMBER(4),
      .LEN_BYTES(1), .RX_TIMEOUT(RXT))
      u_b (.clk(clk), .reset(reset), .bus(if_b));
   uart_frame_parser #(.CLOCK(CLK_HZ), .BAUD(BD), .NUMBER(256),
      .LEN_BYTES(2), .RX_TIMEOUT(RXT))
      u_c (.clk(clk), .reset(reset), .bus(if_c));

   int we_a, done_a, err_a, we_b, done_b, err_b, we_c, done_c, err_c;
   logic [7:0] wa_addr[$];
   logic [7:0] wa_data[$];
   logic [7:0] wc_data[$];

   always @(negedge clk) begin
      if (if_a.we) begin
         we_a++;
         wa_addr.push_back(if_a.wr_addr);
         wa_data.push_back(if_a.wr_data);
      end
      if (if_a.rx_done) done_a++;
      if (if_a.rx_err) err_a++;
      if (if_b.we) we_b++;
      if (if_b.rx_done) done_b++;
      if (if_b.rx_err) err_b++;
      if (if_c.we) begin
         we_c++;
         wc_data.push_back(if_c.wr_data);
      end
      if (if_c.rx_done) done_c++;
      if (if_c.rx_err) err_c++;
      if ((if_a.rx_done && if_a.rx_err) || (if_b.rx_done && if_b.rx_err)
          || (if_c.rx_done && if_c.rx_err)) begin
         failures++;
         $display("FAIL done_err_overlap at %0t", $time);
      end
   end

   task automatic clr();
      we_a = 0; done_a = 0; err_a = 0;
      we_b = 0; done_b = 0; err_b = 0;
      we_c = 0; done_c = 0; err_c = 0;
      wa_addr.delete(); wa_data.delete(); wc_data.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rx_v = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      clr();
   endtask

   task automatic put(input logic [7:0] b);
      rx_d = b;
      rx_v = 1'b1;
      @(posedge clk);
      #1 rx_v = 1'b0;
   endtask

   task automatic put_cs(input logic [7:0] b);
      if (CS) put(b);
   endtask

   task automatic gap(input int n);
      rx_v = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (if_a.cmd_rx !== 8'h00) begin failures++; $display("FAIL rst_cmd got=%h exp=00", if_a.cmd_rx); end
      checks++; if (if_a.len_rx !== 8'h00) begin failures++; $display("FAIL rst_len got=%h exp=00", if_a.len_rx); end
      checks++; if (if_a.wr_data !== 8'h00 || if_a.wr_addr !== 8'h00) begin failures++; $display("FAIL rst_wr got=%h/%h exp=00/00", if_a.wr_data, if_a.wr_addr); end
      checks++; if ({if_a.we, if_a.rx_done, if_a.rx_err, if_a.busy} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {if_a.we, if_a.rx_done, if_a.rx_err, if_a.busy}); end
      checks++; if (if_a.err_code !== 2'd0) begin failures++; $display("FAIL rst_code got=%0d exp=0", if_a.err_code); end
   endtask

   task automatic test_addr_frame();
      logic [7:0] exp_d[4] = '{8'h01, 8'h00, 8'h00, 8'h04};
      do_reset();
      put(8'h41);
      checks++; if (if_a.busy !== 1'b1) begin failures++; $display("FAIL addr_busy got=%b exp=1", if_a.busy); end
      put(8'h04); put(8'h01); put(8'h00); put(8'h00); put(8'h04);
      put_cs(8'hB5);
      checks++; if (if_a.rx_done !== 1'b1 || if_a.busy !== 1'b0) begin failures++; $display("FAIL addr_done_timing got=%b%b exp=10", if_a.rx_done, if_a.busy); end
      gap(3);
      checks++; if (we_a !== 4) begin failures++; $display("FAIL addr_we_count got=%0d exp=4", we_a); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wa_addr.size() || wa_addr[i] !== 8'(i) || wa_data[i] !== exp_d[i]) begin
            failures++;
            $display("FAIL addr_write%0d got=%h/%h exp=%h/%h", i, (i < wa_addr.size()) ? wa_addr[i] : 8'hxx, (i < wa_data.size()) ? wa_data[i] : 8'hxx, 8'(i), exp_d[i]);
         end
      end
      checks++; if (if_a.cmd_rx !== 8'h41 || if_a.len_rx !== 8'h04) begin failures++; $display("FAIL addr_cmd_len got=%h/%h exp=41/04", if_a.cmd_rx, if_a.len_rx); end
      checks++; if (done_a !== 1 || err_a !== 0 || if_a.err_code !== 2'd0) begin failures++; $display("FAIL addr_pulses got=%0d/%0d/%0d exp=1/0/0", done_a, err_a, if_a.err_code); end
   endtask

   task automatic test_zero_single();
      do_reset();
      put(8'h56); put(8'h00);
      put_cs(8'hA9);
      checks++; if (if_a.rx_done !== 1'b1) begin failures++; $display("FAIL zero_done_timing got=%b exp=1", if_a.rx_done); end
      gap(3);
      checks++; if (we_a !== 0 || done_a !== 1 || if_a.len_rx !== 8'h00) begin failures++; $display("FAIL zero_frame got=%0d/%0d/%h exp=0/1/00", we_a, done_a, if_a.len_rx); end
      clr();
      put(8'h56); put(8'h01); put(8'h00);
      put_cs(8'hA8);
      gap(3);
      checks++; if (we_a !== 1 || done_a !== 1 || err_a !== 0) begin failures++; $display("FAIL single_frame got=%0d/%0d/%0d exp=1/1/0", we_a, done_a, err_a); end
      checks++; if (wa_addr.size() != 1 || wa_addr[0] !== 8'h00 || wa_data[0] !== 8'h00) begin failures++; $display("FAIL single_write got=%0d entries exp=1 at 00/00", wa_addr.size()); end
   endtask

   task automatic test_bad_csum();
`ifdef UART_FRAME_CHECKSUM_EN
      do_reset();
      put(8'h41); put(8'h04); put(8'h01); put(8'h00); put(8'h00); put(8'h04); put(8'hB5);
      gap(2);
      clr();
      put(8'h56); put(8'h01); put(8'h00); put(8'hA7);
      checks++; if (if_a.rx_err !== 1'b1 || if_a.err_code !== 2'd1) begin failures++; $display("FAIL csum_err got=%b/%0d exp=1/1", if_a.rx_err, if_a.err_code); end
      gap(5);
      checks++; if (done_a !== 0 || err_a !== 1 || if_a.err_code !== 2'd1) begin failures++; $display("FAIL csum_hold got=%0d/%0d/%0d exp=0/1/1", done_a, err_a, if_a.err_code); end
      checks++; if (if_a.len_rx !== 8'h04 || if_a.cmd_rx !== 8'h56) begin failures++; $display("FAIL csum_len_hold got=%h/%h exp=04/56", if_a.len_rx, if_a.cmd_rx); end
`endif
   endtask

   task automatic test_timeout();
      int n;
      do_reset();
      put(8'h41); put(8'h04); put(8'h01);
      n = 0;
      while (n < TO_LIM + 20 && if_a.rx_err !== 1'b1) begin
         gap(1);
         n++;
      end
      checks++; if (n < TO_LIM - 1 || n > TO_LIM + 1) begin failures++; $display("FAIL timeout_latency got=%0d exp=%0d", n, TO_LIM); end
      checks++; if (if_a.err_code !== 2'd2 || if_a.busy !== 1'b0) begin failures++; $display("FAIL timeout_code got=%0d/%b exp=2/0", if_a.err_code, if_a.busy); end
      gap(2);
      checks++; if (err_a !== 1 || done_a !== 0 || if_a.cmd_rx !== 8'h41) begin failures++; $display("FAIL timeout_pulses got=%0d/%0d/%h exp=1/0/41", err_a, done_a, if_a.cmd_rx); end
      clr();
      put(8'h56); put(8'h00);
      put_cs(8'hA9);
      gap(2);
      checks++; if (done_a !== 1 || if_a.err_code !== 2'd0) begin failures++; $display("FAIL timeout_recover got=%0d/%0d exp=1/0", done_a, if_a.err_code); end
      clr();
      put(8'h41); put(8'h04); put(8'h01);
      gap(TO_LIM - 1);
      put(8'h00); put(8'h00); put(8'h04);
      put_cs(8'hB5);
      gap(2);
      checks++; if (err_a !== 0 || done_a !== 1 || we_a !== 4) begin failures++; $display("FAIL expiry_cycle_byte got=%0d/%0d/%0d exp=0/1/4", err_a, done_a, we_a); end
   endtask

   task automatic test_overflow();
      int n;
      do_reset();
      put(8'h4B); put(8'h05);
      checks++; if (if_b.rx_err !== 1'b1 || if_b.err_code !== 2'd3) begin failures++; $display("FAIL ovf_err got=%b/%0d exp=1/3", if_b.rx_err, if_b.err_code); end
      put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'h55);
      n = 0;
      while (n < TO_LIM + 20 && if_b.busy !== 1'b0) begin
         gap(1);
         n++;
      end
      checks++; if (if_b.busy !== 1'b0 || n < TO_LIM - 1) begin failures++; $display("FAIL ovf_drop_exit got=%b after %0d exp=0 after ~%0d", if_b.busy, n, TO_LIM); end
      gap(2);
      checks++; if (we_b !== 0 || err_b !== 1 || done_b !== 0) begin failures++; $display("FAIL ovf_pulses got=%0d/%0d/%0d exp=0/1/0", we_b, err_b, done_b); end
      clr();
      put(8'h56); put(8'h01); put(8'h00);
      put_cs(8'hA8);
      gap(2);
      checks++; if (done_b !== 1 || if_b.err_code !== 2'd0) begin failures++; $display("FAIL ovf_recover got=%0d/%0d exp=1/0", done_b, if_b.err_code); end
      clr();
      put(8'h4B); put(8'h04); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
      put_cs(8'hA6);
      gap(2);
      checks++; if (done_b !== 1 || we_b !== 4 || if_b.len_rx !== 8'h04) begin failures++; $display("FAIL len_eq_number got=%0d/%0d/%h exp=1/4/04", done_b, we_b, if_b.len_rx); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      put(8'h41); put(8'h04); put(8'h01);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (if_a.cmd_rx !== 8'h00 || if_a.busy !== 1'b0 || if_a.err_code !== 2'd0) begin failures++; $display("FAIL midrst_out got=%h/%b/%0d exp=00/0/0", if_a.cmd_rx, if_a.busy, if_a.err_code); end
      @(posedge clk);
      #1 reset = 1'b0;
      gap(TO_LIM + 10);
      checks++; if (err_a !== 0 || done_a !== 0 || if_a.busy !== 1'b0) begin failures++; $display("FAIL midrst_quiet got=%0d/%0d/%b exp=0/0/0", err_a, done_a, if_a.busy); end
   endtask

   task automatic test_len2();
      do_reset();
      put(8'h4B); put(8'h02); put(8'h00); put(8'hAA); put(8'hBB);
      put_cs(8'h4D);
      checks++; if (if_c.rx_done !== 1'b1) begin failures++; $display("FAIL len2_done got=%b exp=1", if_c.rx_done); end
      gap(2);
      checks++; if (if_c.len_rx !== 16'h0002 || we_c !== 2 || err_c !== 0) begin failures++; $display("FAIL len2_frame got=%h/%0d/%0d exp=0002/2/0", if_c.len_rx, we_c, err_c); end
      checks++; if (wc_data.size() != 2 || wc_data[0] !== 8'hAA || wc_data[1] !== 8'hBB) begin failures++; $display("FAIL len2_data got=%0d entries exp=AA,BB", wc_data.size()); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      put(8'h56); put(8'h00);
      put_cs(8'hA9);
      put(8'h56); put(8'h01); put(8'h00);
      put_cs(8'hA8);
      gap(3);
      checks++; if (done_a !== 2 || we_a !== 1 || err_a !== 0) begin failures++; $display("FAIL b2b got=%0d/%0d/%0d exp=2/1/0", done_a, we_a, err_a); end
      checks++; if (if_a.len_rx !== 8'h01) begin failures++; $display("FAIL b2b_len got=%h exp=01", if_a.len_rx); end
   endtask

   initial begin
      test_reset();
      test_addr_frame();
      test_zero_single();
      test_bad_csum();
      test_timeout();
      test_overflow();
      test_reset_mid();
      test_len2();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Parametrised byte-stream frame parser between the UART byte receiver and the command decoder of the dual-image upgrade controller. It accepts frames of `cmd, len, payload[len], checksum`, writes payload bytes into the command buffer, and reports a completed frame. It generalises the fixed 1-byte-length receiver with:
- a configurable length-field width and buffer depth;
- an inter-byte timeout measured in byte-times;
- explicit error reporting.

## Interface
Parameters:
- `CLOCK`, 50_000_000, system clock in Hz
- `BAUD`, 115_200, UART bit rate
- `NUMBER`, 256, payload buffer depth in bytes (max accepted `len`)
- `LEN_BYTES`, 1, length-field size in bytes (1 or 2, little-endian)
- `RX_TIMEOUT`, 2, inter-byte timeout in byte-times (1 byte-time = 10*CLOCK/BAUD clocks)

Ports:
- `clk` in 1: system clock
- `reset` in 1: synchronous, active-high reset
- `rx_data` in 8: byte from UART receiver
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid
- `cmd_rx` out 8: command byte of last frame
- `len_rx` out 8*LEN_BYTES: payload length of last frame
- `wr_data` out 8: payload byte to buffer
- `wr_addr` out $clog2(NUMBER): buffer address, 0-based within frame
- `we` out 1: buffer write strobe
- `rx_done` out 1: one-cycle pulse, good frame received
- `rx_err` out 1: one-cycle pulse, frame rejected
- `err_code` out 2: 0 none, 1 checksum, 2 timeout, 3 length overflow
- `busy` out 1: high while not in IDLE

## Operation
- States: IDLE, LEN, DATA, CSUM, DROP.
- **IDLE**
  - On `rx_valid`: latch `cmd_rx`, init sum=`rx_data`, byte counter=0, go to LEN.
- **LEN**
  - Collects LEN_BYTES bytes, LSB first, each added to sum.
  - After the last length byte: if len > NUMBER → `rx_err`, `err_code`=3, go to DROP.
  - Else if len = 0 → go to CSUM.
  - Else → go to DATA.
- **DATA**
  - Each `rx_valid`: `wr_data`=`rx_data`, `wr_addr`=counter, `we`=1; sum += byte; counter++.
  - After len bytes → go to CSUM.
- **CSUM**
  - Byte compared to ~sum (8-bit wrap).
  - Match → `rx_done`, `len_rx` updated, `err_code`=0.
  - Mismatch → `rx_err`, `err_code`=1.
  - Either way → IDLE.
- **DROP**
  - Bytes ignored; leaves to IDLE on timeout expiry without a second `rx_err` pulse.
- **Timeout**
  - Counter runs in every non-IDLE state and clears on each `rx_valid`.
  - When it reaches RX_TIMEOUT*10*CLOCK/BAUD: outside DROP → `rx_err`, `err_code`=2, go to IDLE.
- **Other rules**
  - `rx_valid` in the expiry cycle: the byte is accepted and the counter cleared; no timeout.
  - All sum arithmetic is modulo 256.
  - `err_code` holds until the next `rx_done`/`rx_err`.
  - `cmd_rx` holds until the next frame's cmd byte. `len_rx` holds until the next good frame.
  - Payload already written before an error stays in the buffer; the consumer acts only on `rx_done`.

## Timing
- All outputs are registered; response appears the cycle after the `rx_valid` that causes it.
- `we`, `rx_done`, `rx_err`: single-cycle pulses. `rx_done` and `rx_err` are never high together.
- Reset values: all outputs 0; state IDLE; counters and sum 0.
- Reset asserted mid-frame: frame discarded, no `rx_err`.
- `busy` rises the cycle after the cmd byte and falls in the same cycle as `rx_done`/`rx_err`/DROP exit.
- Back-to-back frames: a cmd byte arriving the cycle after `rx_done` is accepted.

## Configuration
- `UART_FRAME_CHECKSUM_EN` defined: the checksum byte is expected and verified as above.
- Not defined:
  - No checksum byte; CSUM is removed.
  - `rx_done` pulses the cycle after the last payload byte, or after the last length byte when len=0.
  - `err_code`=1 is never produced.

## Test plan
- **ADDR frame** (checksum on, NUMBER=256): bytes 41 04 01 00 00 04 B5 → four `we` pulses with addr 0..3, data 01 00 00 04; then `rx_done`, `cmd_rx`=41, `len_rx`=4.
- **Zero-payload / single-byte frames:**
  - 56 00 A9 → no `we`, `rx_done`, `len_rx`=0.
  - 56 01 00 A8 → one `we` (addr 0, data 00), `rx_done`.
- **Bad checksum:** 56 01 00 A7 → `rx_err`, `err_code`=1, no `rx_done`.
- **Timeout:** 41 04 01, then silence > RX_TIMEOUT byte-times → `rx_err`, `err_code`=2, `busy` low. Next frame parses normally.
- **Overflow** (NUMBER=4): 4B 05 + payload bytes → `rx_err`, `err_code`=3 after the len byte, no `we`. After a timeout gap, a valid frame gives `rx_done`.
- **Reset / LEN_BYTES=2:**
  - Reset asserted after 41 04 01 → outputs 0, IDLE, no pulses.
  - With LEN_BYTES=2: 4B 02 00 AA BB csum=~(4B+02+00+AA+BB)=~B2=4D → `rx_done`, `len_rx`=0002.
